// File: rtl/store_byte_merge_if.sv
// Request and memory-side bus of the sub-word store unit.
// The requester/memory model uses master, the store unit uses slave.
interface store_byte_merge_if;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;

    modport master (
        output req, size, addr, wdata,
        output mem_rdata, mem_rvalid,
        input  busy, done,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  req, size, addr, wdata,
        input  mem_rdata, mem_rvalid,
        output busy, done,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/store_byte_merge.sv
// Sub-word store unit: SB/SH as read-modify-write, SW written directly.
// Little-endian lanes; all outputs come straight from registers.
module store_byte_merge (
    input  logic                 clock,
    input  logic                 reset,
    store_byte_merge_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [15:0] wdata_q;
    logic [31:0] merge_q;
    logic        busy_q;
    logic        done_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] merged;

    // Replace the addressed byte/halfword lane of the returned word
    always_comb begin
        merged = bus.mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = bus.mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Store sequencer with registered strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        addr_q  <= bus.addr;
                        size_q  <= bus.size;
                        wdata_q <= bus.wdata[15:0];
                        busy_q  <= 1'b1;
                        if (!bus.size[1]) begin
                            state <= READ;
                            rd_q  <= 1'b1;
                        end else begin
                            state   <= WRITE;
                            merge_q <= bus.wdata;
                            wr_q    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (bus.mem_rvalid) begin
                        state   <= WRITE;
                        merge_q <= merged;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    state  <= DONE;
                    wr_q   <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = merge_q;

endmodule

// File: tb/tb_store_byte_merge.sv
// Bench for store_byte_merge: scoreboard of expected write words,
// cycle-accurate checks of read/write/done timing and reset abort.
module tb_store_byte_merge;

    logic clock = 1'b0;
    logic reset = 1'b0;

    store_byte_merge_if bus();

    store_byte_merge dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] expa_q[$];

    task automatic pop_check(input string name);
        logic [31:0] e;
        logic [31:0] ea;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected write %h, nothing queued",
                     name, bus.mem_wdata);
        end else begin
            e  = exp_q.pop_front();
            ea = expa_q.pop_front();
            if (bus.mem_wdata !== e) begin
                n_fail++;
                $display("FAIL %s wdata: got %h want %h",
                         name, bus.mem_wdata, e);
            end
            n_checks++;
            if (bus.mem_addr !== ea) begin
                n_fail++;
                $display("FAIL %s addr: got %h want %h",
                         name, bus.mem_addr, ea);
            end
        end
    endtask

    task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] mw,
                             input int w, input logic [31:0] expd,
                             input string name);
        int rd_n = 0;
        int wr_n = 0;
        int wr_c = -1;
        int done_c = -1;
        bit busy_ok = 1'b1;
        int exp_wr;
        int exp_rd;
        exp_wr = sz[1] ? 1 : 2 + w;
        exp_rd = sz[1] ? 0 : 1 + w;
        exp_q.push_back(expd);
        expa_q.push_back({a[31:2], 2'b00});
        @(negedge clock);
        bus.req   = 1'b1;
        bus.size  = sz;
        bus.addr  = a;
        bus.wdata = wd;
        for (int c = 1; c <= 12 + w; c++) begin
            @(negedge clock);
            if (c == 1) bus.req = 1'b0;
            if (bus.mem_rd) begin
                rd_n++;
                if (!bus.busy) busy_ok = 1'b0;
            end
            bus.mem_rvalid = bus.mem_rd && (rd_n == w + 1);
            bus.mem_rdata  = bus.mem_rvalid ? mw : 32'hA5A5_0F0F;
            if (bus.mem_wr) begin
                wr_n++;
                wr_c = c;
                if (!bus.busy) busy_ok = 1'b0;
                pop_check(name);
            end
            if (bus.done) done_c = c;
            if (done_c > 0 && c == done_c + 1) begin
                n_checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s idle: busy=%b done=%b want 0 0",
                             name, bus.busy, bus.done);
                end
            end
        end
        n_checks++;
        if (wr_n != 1 || wr_c != exp_wr) begin
            n_fail++;
            $display("FAIL %s write: count %0d cycle %0d want 1 at %0d",
                     name, wr_n, wr_c, exp_wr);
        end
        n_checks++;
        if (done_c != exp_wr + 1) begin
            n_fail++;
            $display("FAIL %s done: cycle %0d want %0d",
                     name, done_c, exp_wr + 1);
        end
        n_checks++;
        if (rd_n != exp_rd) begin
            n_fail++;
            $display("FAIL %s reads: got %0d want %0d", name, rd_n, exp_rd);
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL %s busy: got 0 want 1 during read/write", name);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_rd !== 1'b0 ||
            bus.mem_wr !== 1'b0 || bus.mem_addr !== 32'h0 ||
            bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: b%b d%b r%b w%b a%h wd%h want all 0", name,
                     bus.busy, bus.done, bus.mem_rd, bus.mem_wr,
                     bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_reset();
        bus.req = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0;
        bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_all_zero("idle_no_req");
    endtask

    task automatic test_sb();
        run_store(2'b00, 32'h102, 32'hFFFF_FFAB, 32'h1122_3344, 0,
                  32'h11AB_3344, "sb");
    endtask

    task automatic test_sh();
        run_store(2'b01, 32'h203, 32'h0000_BEEF, 32'h1122_3344, 0,
                  32'hBEEF_3344, "sh_hi");
        run_store(2'b01, 32'h200, 32'h0000_BEEF, 32'h1122_3344, 1,
                  32'h1122_BEEF, "sh_lo");
    endtask

    task automatic test_sw();
        run_store(2'b10, 32'h303, 32'hDEAD_BEEF, 32'h1122_3344, 0,
                  32'hDEAD_BEEF, "sw");
        run_store(2'b11, 32'h306, 32'hCAFE_F00D, 32'h1122_3344, 0,
                  32'hCAFE_F00D, "sw_size3");
    endtask

    task automatic test_lanes();
        logic [31:0] e;
        for (int k = 0; k < 4; k++) begin
            e = 32'h5A << (8 * k);
            run_store(2'b00, 32'h500 + k, 32'h0000_005A, 32'h0, 3, e, "lane");
        end
    endtask

    task automatic test_reset_mid();
        int wr_n = 0;
        @(negedge clock);
        bus.req = 1'b1; bus.size = 2'b00;
        bus.addr = 32'h601; bus.wdata = 32'h77;
        bus.mem_rvalid = 1'b0;
        @(negedge clock);
        bus.req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid");
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clock);
            if (bus.mem_wr) wr_n++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (bus.mem_wr) wr_n++;
        end
        bus.mem_rvalid = 1'b0;
        n_checks++;
        if (wr_n != 0) begin
            n_fail++;
            $display("FAIL reset_abort: writes %0d want 0", wr_n);
        end
        run_store(2'b00, 32'h603, 32'h0000_0042, 32'h1111_1111, 0,
                  32'h4211_1111, "after_reset");
    endtask

    task automatic test_back_to_back();
        int wr_c[$];
        exp_q.push_back(32'h1234_5678);
        expa_q.push_back(32'h400);
        exp_q.push_back(32'h1234_5678);
        expa_q.push_back(32'h400);
        @(negedge clock);
        bus.req = 1'b1; bus.size = 2'b10;
        bus.addr = 32'h401; bus.wdata = 32'h1234_5678;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (c == 4) bus.req = 1'b0;
            if (bus.mem_wr) begin
                wr_c.push_back(c);
                pop_check("b2b");
            end
        end
        n_checks++;
        if (wr_c.size() != 2) begin
            n_fail++;
            $display("FAIL b2b count: got %0d want 2", wr_c.size());
        end else begin
            n_checks++;
            if (wr_c[0] != 1 || wr_c[1] != 4) begin
                n_fail++;
                $display("FAIL b2b cycles: got %0d,%0d want 1,4",
                         wr_c[0], wr_c[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_sw();
        test_lanes();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d queued writes never seen",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
